display_scan: RTL

- Time-multiplexed driver for the 8-digit seven-segment display.
- Sits directly upstream of the 3-to-8 digit decoder: produces the 3-bit digit index `num` that the decoder turns into active-low digit selects.
- Produces the matching active-low segment pattern for the hex nibble of a 32-bit value.
- Holds a double-buffered copy of the value so a digit refresh never tears mid-frame.

---
 rtl/display_scan_pkg.sv | 27 ++
 rtl/hex_to_seg.sv | 33 +++
 rtl/display_scan.sv | 116 +++++++++++
 3 files changed

// File: rtl/display_scan_pkg.sv
// rtl/display_scan_pkg.sv - constants and types shared by the digit scanner and its font decoder
package display_scan_pkg;
  localparam logic [7:0] FONT_0    = 8'hC0;
  localparam logic [7:0] FONT_1    = 8'hF9;
  localparam logic [7:0] FONT_2    = 8'hA4;
  localparam logic [7:0] FONT_3    = 8'hB0;
  localparam logic [7:0] FONT_4    = 8'h99;
  localparam logic [7:0] FONT_5    = 8'h92;
  localparam logic [7:0] FONT_6    = 8'h82;
  localparam logic [7:0] FONT_7    = 8'hF8;
  localparam logic [7:0] FONT_8    = 8'h80;
  localparam logic [7:0] FONT_9    = 8'h90;
  localparam logic [7:0] FONT_A    = 8'h88;
  localparam logic [7:0] FONT_B    = 8'h83;
  localparam logic [7:0] FONT_C    = 8'hC6;
  localparam logic [7:0] FONT_D    = 8'hA1;
  localparam logic [7:0] FONT_E    = 8'h86;
  localparam logic [7:0] FONT_F    = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DIGITS    = 8;

  localparam int NUM_W  = $clog2(DIGITS);
  localparam int DATA_W = 4 * DIGITS;

  typedef logic [NUM_W-1:0] digit_t;
  typedef logic [3:0]       nibble_t;
endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low a..g segment pattern
module hex_to_seg
  import display_scan_pkg::*;
(
  input  nibble_t    nibble,
  output logic [6:0] seg_n
);

  // look up the glyph for one hex digit; dp is handled by the caller
  always_comb begin
    seg_n = SEG_BLANK[6:0];
    case (nibble)
      4'h0:    seg_n = FONT_0[6:0];
      4'h1:    seg_n = FONT_1[6:0];
      4'h2:    seg_n = FONT_2[6:0];
      4'h3:    seg_n = FONT_3[6:0];
      4'h4:    seg_n = FONT_4[6:0];
      4'h5:    seg_n = FONT_5[6:0];
      4'h6:    seg_n = FONT_6[6:0];
      4'h7:    seg_n = FONT_7[6:0];
      4'h8:    seg_n = FONT_8[6:0];
      4'h9:    seg_n = FONT_9[6:0];
      4'hA:    seg_n = FONT_A[6:0];
      4'hB:    seg_n = FONT_B[6:0];
      4'hC:    seg_n = FONT_C[6:0];
      4'hD:    seg_n = FONT_D[6:0];
      4'hE:    seg_n = FONT_E[6:0];
      4'hF:    seg_n = FONT_F[6:0];
      default: seg_n = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - 8-digit seven-segment scan driver, double-buffered; DISPLAY_SCAN_BLANK_EN adds leading-zero blanking
module display_scan
  import display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  input  logic [DIGITS-1:0] dp,
  output logic [NUM_W-1:0]  num,
  output logic [7:0]        seg,
  output logic              frame_done
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  digit_t            num_q, num_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic              pending_flag_q, pending_flag_d;
  logic [DATA_W-1:0] shown_q, shown_d;
  logic [7:0]        seg_q, seg_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              boundary;
  nibble_t           cur_nibble;
  logic [6:0]        font_n;
  logic [6:0]        glyph;

  assign tick     = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign boundary = tick && (num_q == digit_t'(DIGITS - 1));

  // prescaler, digit index and the pending/shown double buffer
  always_comb begin
    cnt_d          = tick ? '0 : cnt_q + CNT_W'(1);
    num_d          = tick ? num_q + digit_t'(1) : num_q;
    frame_done_d   = boundary;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    shown_d        = shown_q;
    if (boundary) begin
      // a strobe landing on the boundary bypasses pending so digit 0 already shows it
      pending_flag_d = 1'b0;
      if (data_valid) begin
        shown_d = data;
      end else if (pending_flag_q) begin
        shown_d = pending_q;
      end
    end else if (data_valid) begin
      pending_d      = data;
      pending_flag_d = 1'b1;
    end
  end

  // nibble for the digit that will be lit after this edge
  assign cur_nibble = shown_d[{num_d, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg_n  (font_n)
  );

`ifdef DISPLAY_SCAN_BLANK_EN
  logic [DIGITS-1:0] nz;
  digit_t            top_digit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nz
    assign nz[g] = |shown_d[4*g +: 4];
  end

  // highest nonzero digit; digit 0 is the floor so a zero value still draws "0"
  always_comb begin
    top_digit = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (nz[i]) top_digit = i[NUM_W-1:0];
    end
  end

  assign glyph = (num_d > top_digit) ? SEG_BLANK[6:0] : font_n;
`else
  assign glyph = font_n;
`endif

  // segment drive follows the new digit index; dp is taken live
  always_comb begin
    seg_d = {~dp[num_d], glyph};
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      num_q          <= '0;
      pending_q      <= '0;
      pending_flag_q <= 1'b0;
      shown_q        <= '0;
      seg_q          <= FONT_0;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      num_q          <= num_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      shown_q        <= shown_d;
      seg_q          <= seg_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
